// File: rtl/trigger_sequencer_if.sv
// Command/status bundle between a trigger_sequencer and whatever drives it
// (software bridge or upstream FSM).
interface trigger_sequencer_if #(parameter int W = 8);
  logic         start;
  logic         stop;
  logic [W-1:0] period_in;
  logic [W-1:0] count_in;
  logic         busy;
  logic         trigger;
  logic         done;
  logic         err;
  logic [W-1:0] trig_cnt;

  modport master (
    output start, stop, period_in, count_in,
    input  busy, trigger, done, err, trig_cnt
  );

  modport slave (
    input  start, stop, period_in, count_in,
    output busy, trigger, done, err, trig_cnt
  );
endinterface

// File: rtl/trigger_sequencer.sv
// Programmable trigger train generator: emits single-cycle pulses every
// per clocks, for rem pulses (or forever when rem is 0), until stopped.
module trigger_sequencer #(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst,
  trigger_sequencer_if.slave bus
);

  localparam logic [0:0]   IDLE = 1'b0;
  localparam logic [0:0]   RUN  = 1'b1;
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [0:0]   state_r;
  logic [W-1:0] cnt_r;
  logic [W-1:0] per_r;
  logic [W-1:0] rem_r;
  logic [W-1:0] trig_cnt_r;
  logic         busy_r;
  logic         trigger_r;
  logic         done_r;
  logic         err_r;
  logic         terminal_s;

  // Last clock of the current period; per_r is never 0 while running.
  always_comb begin
    terminal_s = (cnt_r == (per_r - ONE));
  end

  // Sequencer state, counters and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= ZERO;
      per_r      <= ZERO;
      rem_r      <= ZERO;
      trig_cnt_r <= ZERO;
      busy_r     <= 1'b0;
      trigger_r  <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      trigger_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (bus.period_in == ZERO) begin
              err_r <= 1'b1;
            end else begin
              state_r    <= RUN;
              busy_r     <= 1'b1;
              per_r      <= bus.period_in;
              rem_r      <= bus.count_in;
              cnt_r      <= ZERO;
              trig_cnt_r <= ZERO;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            // Abort wins over a coinciding terminal count; trig_cnt is kept.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= ZERO;
          end else if (terminal_s) begin
            cnt_r      <= ZERO;
            trigger_r  <= 1'b1;
            trig_cnt_r <= trig_cnt_r + ONE;
            if (rem_r == ONE) begin
              rem_r   <= ZERO;
              done_r  <= 1'b1;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else if (rem_r != ZERO) begin
              rem_r <= rem_r - ONE;
            end else begin
              rem_r <= rem_r;
            end
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= ZERO;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.trigger  = trigger_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.trig_cnt = trig_cnt_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: timeline model compared every cycle, plus
// literal pulse-pattern checks for the documented scenarios.
module tb_trigger_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;

  trigger_sequencer_if #(.W(8)) bus ();

  trigger_sequencer #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Model: a run is a timeline anchored at its start edge; a pulse lands on
  // every edge whose distance from the anchor is a multiple of the period.
  logic       m_run = 1'b0;
  logic       m_busy = 1'b0, m_trigger = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [7:0] m_trig_cnt = 8'd0;
  int         m_per = 1, m_total = 0, m_issued = 0, m_anchor = 0;

  always @(posedge clk) begin
    m_trigger <= 1'b0;
    m_done    <= 1'b0;
    m_err     <= 1'b0;
    if (!rst) begin
      m_run      <= 1'b0;
      m_busy     <= 1'b0;
      m_trig_cnt <= 8'd0;
    end else if (!m_run) begin
      if (bus.start && !bus.stop) begin
        if (bus.period_in == 8'd0) begin
          m_err <= 1'b1;
        end else begin
          m_run      <= 1'b1;
          m_busy     <= 1'b1;
          m_per      <= int'(bus.period_in);
          m_total    <= int'(bus.count_in);
          m_issued   <= 0;
          m_anchor   <= edge_no;
          m_trig_cnt <= 8'd0;
        end
      end
    end else if (bus.stop) begin
      m_run  <= 1'b0;
      m_busy <= 1'b0;
    end else if (((edge_no - m_anchor) % m_per) == 0) begin
      m_trigger  <= 1'b1;
      m_trig_cnt <= m_trig_cnt + 8'd1;
      m_issued   <= m_issued + 1;
      if (m_total != 0 && m_issued + 1 == m_total) begin
        m_done <= 1'b1;
        m_run  <= 1'b0;
        m_busy <= 1'b0;
      end
    end
    edge_no <= edge_no + 1;
  end

  // Every cycle after the first edge the DUT must match the model.
  always @(negedge clk) begin
    if (edge_no > 0) begin
      check("busy",     {31'd0, bus.busy},     {31'd0, m_busy});
      check("trigger",  {31'd0, bus.trigger},  {31'd0, m_trigger});
      check("done",     {31'd0, bus.done},     {31'd0, m_done});
      check("err",      {31'd0, bus.err},      {31'd0, m_err});
      check("trig_cnt", {24'd0, bus.trig_cnt}, {24'd0, m_trig_cnt});
    end
  end

  // Issue a start at the next edge (edge 0); returns in cycle 0 at negedge.
  task automatic do_start(input logic [7:0] p, input logic [7:0] c);
    bus.start     = 1'b1;
    bus.period_in = p;
    bus.count_in  = c;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Record outputs for cycles 0..n-1 (bit k = cycle k) with optional
  // stop / ignored-restart / reset applied at a given edge (-1 = none).
  task automatic run_cycles(input int n, input int stop_at, input int restart_at, input int rst_at,
                            output logic [31:0] tv, output logic [31:0] dv,
                            output logic [31:0] bv, output logic [31:0] ev);
    tv = 32'd0; dv = 32'd0; bv = 32'd0; ev = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (k < 32) begin
        tv[k] = bus.trigger;
        dv[k] = bus.done;
        bv[k] = bus.busy;
        ev[k] = bus.err;
      end
      bus.stop  = (k + 1 == stop_at);
      bus.start = (k + 1 == restart_at);
      if (k + 1 == restart_at) bus.period_in = 8'd7;
      rst = !(k + 1 == rst_at);
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [31:0] tv, dv, bv, ev;
  int          r;

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.period_in = 8'd0;
    bus.count_in  = 8'd0;
    rst           = 1'b0;
    idle(2);
    check("reset_busy",     {31'd0, bus.busy},     32'd0);
    check("reset_trig_cnt", {24'd0, bus.trig_cnt}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Bounded run: period 3, four pulses.
    do_start(8'd3, 8'd4);
    run_cycles(14, -1, -1, -1, tv, dv, bv, ev);
    check("t1_trigger", tv, 32'h0000_1248);
    check("t1_done",    dv, 32'h0000_1000);
    check("t1_busy",    bv, 32'h0000_0FFF);
    check("t1_cnt",     {24'd0, bus.trig_cnt}, 32'd4);
    idle(2);

    // Continuous period 1, stopped at edge 10.
    do_start(8'd1, 8'd0);
    run_cycles(12, 10, -1, -1, tv, dv, bv, ev);
    check("t2_trigger", tv, 32'h0000_03FE);
    check("t2_done",    dv, 32'h0000_0000);
    check("t2_busy",    bv, 32'h0000_03FF);
    check("t2_cnt",     {24'd0, bus.trig_cnt}, 32'd9);
    idle(2);

    // Zero period is rejected.
    do_start(8'd0, 8'd3);
    run_cycles(4, -1, -1, -1, tv, dv, bv, ev);
    check("t3_err",     ev, 32'h0000_0001);
    check("t3_busy",    bv, 32'h0000_0000);
    check("t3_trigger", tv, 32'h0000_0000);
    idle(2);

    // Stop on the final terminal edge suppresses the last pulse and done.
    do_start(8'd4, 8'd2);
    run_cycles(10, 8, -1, -1, tv, dv, bv, ev);
    check("t4_trigger", tv, 32'h0000_0010);
    check("t4_done",    dv, 32'h0000_0000);
    check("t4_busy",    bv, 32'h0000_00FF);
    bus.stop = 1'b1;
    do_start(8'd5, 8'd1);
    bus.stop = 1'b0;
    check("t4_start_stop_idle", {31'd0, bus.busy}, 32'd0);
    idle(2);

    // Start during a run is ignored.
    do_start(8'd2, 8'd5);
    run_cycles(13, -1, 3, -1, tv, dv, bv, ev);
    check("t5_trigger", tv, 32'h0000_0554);
    check("t5_done",    dv, 32'h0000_0400);
    idle(2);

    // Reset mid-run, then a fresh single-pulse run.
    do_start(8'd3, 8'd0);
    run_cycles(7, -1, -1, 5, tv, dv, bv, ev);
    check("t6_trigger", tv, 32'h0000_0008);
    check("t6_busy",    bv, 32'h0000_001F);
    check("t6_cnt",     {24'd0, bus.trig_cnt}, 32'd0);
    do_start(8'd2, 8'd1);
    run_cycles(4, -1, -1, -1, tv, dv, bv, ev);
    check("t6_trigger2", tv, 32'h0000_0004);
    check("t6_done2",    dv, 32'h0000_0004);
    idle(2);

    // trig_cnt wraps: 299 pulses leave 43.
    do_start(8'd1, 8'd0);
    run_cycles(302, 300, -1, -1, tv, dv, bv, ev);
    check("wrap_cnt", {24'd0, bus.trig_cnt}, 32'd43);
    idle(2);

    // Randomised traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.stop      = ($urandom_range(0, 39) == 0);
      bus.period_in = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'hFF : 8'($urandom_range(1, 6));
      bus.count_in  = 8'($urandom_range(0, 5));
      rst           = ($urandom_range(0, 199) != 0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
Programmable controller for the periodic-trigger datapath. It sequences a bounded or continuous train of single-cycle trigger pulses with a run-time period and pulse count. Software or an upstream FSM drives it with a start/stop command interface and gets busy/done/err status back. It replaces fixed-period trigger instances wherever the period or number of pulses must change at run time.

Parameters:
W, 8, width of period, pulse-count and internal counters
(no other parameters)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
start  input  1  launch request, sampled only in IDLE
stop  input  1  abort request, sampled every cycle
period_in  input  W  trigger period in clocks, latched at accepted start
count_in  input  W  number of triggers to issue, latched at accepted start; 0 = continuous
busy  output  1  registered, high while in RUN
trigger  output  1  registered single-cycle trigger pulse
done  output  1  registered one-cycle pulse, coincident with last trigger of a bounded run
err  output  1  registered one-cycle pulse, start rejected because period_in == 0
trig_cnt  output  W  triggers issued in current/last run, wraps modulo 2^W

Behaviour:
- Reset (rst low at an edge): state IDLE, busy=0, trigger=0, done=0, err=0, trig_cnt=0, internal cnt=0, per=0, rem=0. Reset overrides all inputs, including mid-run.
- Cycle k means the interval after rising edge k. All outputs are flops with no combinational input-to-output paths.
- The FSM has 2 states, IDLE and RUN. trigger, done and err default to 0 every edge unless set below.
- IDLE, stop=1: stay IDLE. stop beats start in the same cycle.
- IDLE, start=1, stop=0, period_in=0: err<=1, stay IDLE, no other change.
- IDLE, start=1, stop=0, period_in!=0: state<=RUN, busy<=1, per<=period_in, rem<=count_in, cnt<=0, trig_cnt<=0.
- RUN, stop=1: state<=IDLE, busy<=0, cnt<=0, trigger<=0, done<=0. The current trig_cnt is held. stop beats a terminal count in the same edge, so no trigger and no done.
- RUN, stop=0, cnt != per-1: cnt<=cnt+1.
- RUN, stop=0, cnt == per-1 (terminal): cnt<=0, trigger<=1, trig_cnt<=trig_cnt+1.
  - If rem==1: rem<=0, done<=1, state<=IDLE, busy<=0. The last trigger, done and busy falling all happen in the same cycle.
  - If rem>1: rem<=rem-1.
  - If rem==0 (continuous): rem is unchanged and the run continues until stop.
- Timing: with start accepted at edge 0, triggers are high in cycles per, 2*per, 3*per, and so on. Pulses are exactly per clocks apart. per=1 gives trigger high every cycle.
- start while in RUN is ignored: no restart and no relatch. period_in and count_in changes during RUN have no effect.
- A new start may be accepted in the cycle after done, once state is IDLE.
- cnt, per and rem are W bits wide. period_in = 2^W-1 is legal. The trig_cnt wrap is silent.

Test Plan:
1. W=8, start at edge 0 with period_in=3, count_in=4 -> trigger high in cycles 3,6,9,12 only; done high in cycle 12 only; busy high in cycles 0-11, low from cycle 12; trig_cnt=4 after cycle 12.
2. period_in=1, count_in=0, start at edge 0, stop at edge 10 -> trigger high in cycles 1-9, low from cycle 10; busy drops in cycle 10; done never asserts; trig_cnt=9.
3. period_in=0, start=1 -> err high for exactly one cycle, busy stays 0, no trigger.
4. period_in=4, count_in=2: stop asserted at edge 8, which is the final terminal edge -> trigger only in cycle 4, no done, busy low in cycle 8; start and stop together in IDLE -> remains IDLE.
5. period_in=2, count_in=5, start at edge 0; at edge 3 drive start=1 with period_in=7 -> ignored; triggers stay at cycles 2,4,6,8,10; done in cycle 10.
6. rst driven low at edge 5 of a continuous run, then released -> all outputs 0 from cycle 5; a fresh start with period_in=2, count_in=1 gives trigger and done in the 2nd cycle after acceptance.
